uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: the successor to the fixed 8-bit, fixed-oversampling receiver top. One self-contained block holds:
- input synchroniser;
- oversampling edge/bit counters;
- majority-vote sampler;
- frame FSM;
- deserialiser.

It adds configurable data width and prescale, optional runtime-selectable parity, a one-cycle `data_valid` strobe and parity/stop error flags. It sits between the serial pin and the byte-consuming logic, clocked by the oversampling clock.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal 5..9.
- `PRESCALE`, default 8: clk cycles per bit, legal 4..32. Must be even.
- `clk`  in  1: oversampling clock (PRESCALE × baud).
- `rst`  in  1: one clock; reset is asynchronous and active-low.
- `RX_IN`  in  1: serial line, idle high, asynchronous to clk.
- `par_en`  in  1: parity bit present in frame. Sampled only in IDLE.
- `par_typ`  in  1: 0 = even, 1 = odd. Sampled only in IDLE.
- `p_data`  out  DATA_WIDTH: last good frame, LSB received first.
- `data_valid`  out  1: one-cycle strobe; `p_data` is new.
- `par_err`  out  1: one-cycle strobe, parity mismatch.
- `stp_err`  out  1: one-cycle strobe, stop bit sampled 0.

## Operation
- `RX_IN` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised bit `rx_s`.
- Edge counter, width clog2(PRESCALE):
  - counts 0..PRESCALE-1 while the FSM is not IDLE, then wraps to 0;
  - held at 0 in IDLE.
- Bit counter, width clog2(DATA_WIDTH+1): increments on each edge-counter wrap in DATA.
- Sampler takes `rx_s` at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The sampled bit is the 2-of-3 majority, valid from edge count PRESCALE/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `rx_s`=0. Latch `par_en`/`par_typ` on this transition.
  - START: at wrap, → DATA if the sampled bit is 0. Otherwise → IDLE (glitch reject, no flags).
  - DATA: the sampled bit shifts into the MSB of the shift register (right shift). After DATA_WIDTH wraps, → PARITY if latched `par_en`, else → STOP.
  - PARITY: compute the expected bit as XOR(shift reg) ^ `par_typ`. Record a mismatch flag. At wrap, → STOP.
  - STOP: evaluate at edge count PRESCALE/2+2. Then → IDLE immediately, not waiting for the wrap, so a back-to-back start bit is not missed.
- STOP evaluation, in one cycle:
  - `stp_err` = sampled bit is 0.
  - `par_err` = mismatch recorded.
  - If neither flag is set: `p_data` ← shift reg and `data_valid`=1.
- Erroneous frames leave `p_data` unchanged. Both error flags may pulse together.
- Reset mid-frame: everything returns to reset values asynchronously. The partial frame is discarded, with no strobes.

## Timing
- Reset values:
  - `p_data`=0; `data_valid`, `par_err`, `stp_err`=0;
  - FSM=IDLE; counters=0; synchroniser=1.
- Latency from the falling edge of `RX_IN` to IDLE→START: 2–3 clk (synchroniser).
- Strobes are asserted for exactly one clk, registered outputs.
- Strobe cycle: (1 + DATA_WIDTH + par_en) × PRESCALE + PRESCALE/2 + 2 clk after START entry.
- A start bit may begin anywhere from PRESCALE/2-2 clk after the stop-bit centre, and is still received correctly.
- `par_en`/`par_typ` changes mid-frame have no effect until the next IDLE→START.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, parity calculation, `par_en`/`par_typ` latches and `par_err` logic are compiled in.
- Undefined:
  - PARITY state is absent and DATA → STOP always.
  - `par_en`/`par_typ` ports remain but are ignored.
  - `par_err` is tied 0.
  - Frame is start + DATA_WIDTH + stop.

## Test plan
All scenarios use DATA_WIDTH=8 and PRESCALE=8 (8 clk/bit) unless noted.
- Frame 0xA5, par_en=1, even, parity bit 0, stop 1 → `data_valid` pulse, `p_data`=0xA5, no error flags.
- Same frame, odd parity selected, parity bit 0 → `par_err` pulse, no `data_valid`, `p_data` keeps its previous value. With the macro undefined, the bench drives frames without parity and `par_err` stays 0.
- Frame 0x3C, par_en=0, stop bit driven 0 → `stp_err` pulse, `p_data` unchanged.
- 3-clk low glitch on idle line → FSM returns to IDLE, no strobes. A single-clk flipped sample inside a data bit (majority) → byte still correct.
- Back-to-back frames 0x55 then 0xAA, second start edge immediately after the first stop bit → two `data_valid` pulses with the correct bytes.
- `rst` asserted low during bit 4 of a frame → all outputs 0 immediately. A following clean frame 0x81 is received correctly. Also repeat the clean-frame check with DATA_WIDTH=7, PRESCALE=16.

Source files
------------

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised oversampling UART receiver. It contains the input
//            synchroniser, edge/bit counters, a 2-of-3 majority sampler, the
//            frame FSM and the deserialiser.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   PRESCALE    clk cycles per bit (even, 4..32)
// Ports:
//   clk         oversampling clock (PRESCALE x baud)
//   rst         asynchronous reset, active low
//   RX_IN       serial line, idle high, asynchronous to clk
//   par_en      parity bit present (latched on IDLE->START)
//   par_typ     0 = even, 1 = odd (latched on IDLE->START)
//   p_data      last good frame, LSB received first
//   data_valid  one-cycle strobe, p_data updated
//   par_err     one-cycle strobe, parity mismatch
//   stp_err     one-cycle strobe, stop bit sampled low
// Build option:
//   UART_RX_PARITY_EN  defined: parity state and checking compiled in.
//                      undefined: frame is start + data + stop, par_err = 0.
// ============================================================================
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int c_EW = $clog2(PRESCALE);
    localparam int c_BW = $clog2(DATA_WIDTH + 1);

    localparam logic [c_EW-1:0] c_EDGE_LAST = c_EW'(PRESCALE - 1);
    localparam logic [c_EW-1:0] c_SMP0      = c_EW'(PRESCALE / 2 - 1);
    localparam logic [c_EW-1:0] c_SMP1      = c_EW'(PRESCALE / 2);
    localparam logic [c_EW-1:0] c_SMP2      = c_EW'(PRESCALE / 2 + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    rx_meta_q;
    logic                    rx_s_q;
    logic [c_EW-1:0]         edge_q;
    logic [c_EW-1:0]         edge_d;
    logic [c_BW-1:0]         bit_q;
    logic                    smp0_q;
    logic                    smp1_q;
    logic                    smp2_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_d;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    data_valid_q;
    logic                    stp_err_q;
    logic                    w_wrap;
    logic                    w_s2;
    logic                    w_vote;

`ifdef UART_RX_PARITY_EN
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    mismatch_q;
    logic                    par_err_q;
`else
    logic                    w_unused_par;
    assign w_unused_par = par_en ^ par_typ;
`endif

    assign w_wrap  = (edge_q == c_EDGE_LAST);
    assign edge_d  = w_wrap ? '0 : edge_q + 1'b1;

    // The third sample is taken from the live synchronised bit on its own
    // count, so the vote is already complete in that cycle. This keeps the
    // wrap decision valid even for PRESCALE=4, where the third sample point
    // is the wrap count itself.
    assign w_s2    = (edge_q == c_SMP2) ? rx_s_q : smp2_q;
    assign w_vote  = (smp0_q & smp1_q) | (smp0_q & w_s2) | (smp1_q & w_s2);

    // Right shift: the first received bit ends up in bit 0.
    assign shift_d = {w_vote, shift_q[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_q       <= '0;
            bit_q        <= '0;
            smp0_q       <= 1'b1;
            smp1_q       <= 1'b1;
            smp2_q       <= 1'b1;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            stp_err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            data_valid_q <= 1'b0;
            stp_err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
            if (state_q != S_IDLE) begin
                if (edge_q == c_SMP0) smp0_q <= rx_s_q;
                if (edge_q == c_SMP1) smp1_q <= rx_s_q;
                if (edge_q == c_SMP2) smp2_q <= rx_s_q;
            end

            case (state_q)
                S_IDLE: begin
                    edge_q <= '0;
                    bit_q  <= '0;
                    if (!rx_s_q) begin
                        state_q    <= S_START;
`ifdef UART_RX_PARITY_EN
                        par_en_q   <= par_en;
                        par_typ_q  <= par_typ;
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    edge_q <= edge_d;
                    // A start bit that votes high was a glitch: drop silently.
                    if (w_wrap) state_q <= w_vote ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    edge_q <= edge_d;
                    if (w_wrap) begin
                        shift_q <= shift_d;
                        if (bit_q == c_BIT_LAST) begin
                            bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= par_en_q ? S_PARITY : S_STOP;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    edge_q <= edge_d;
                    if (w_wrap) begin
                        mismatch_q <= (w_vote != ((^shift_q) ^ par_typ_q));
                        state_q    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    edge_q <= edge_d;
                    // Decide on the third sample and leave straight away so a
                    // start bit following the stop-bit centre is not missed.
                    // The strobes become visible as the count reaches
                    // PRESCALE/2+2.
                    if (edge_q == c_SMP2) begin
                        stp_err_q <= ~w_vote;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= mismatch_q;
                        if (w_vote && !mismatch_q) begin
`else
                        if (w_vote) begin
`endif
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                        edge_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    edge_q  <= '0;
                end
            endcase
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign stp_err    = stp_err_q;
`ifdef UART_RX_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Directed self-checking bench for uart_rx_param. One instance at
//            DATA_WIDTH=8/PRESCALE=8 carries most scenarios, a second at
//            DATA_WIDTH=7/PRESCALE=16 receives a clean frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam bit c_PAR_BUILD = 1'b1;
`else
    localparam bit c_PAR_BUILD = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rx8     = 1'b1;
    logic       rx7     = 1'b1;
    logic       par_en  = 1'b0;
    logic       par_typ = 1'b0;

    logic [7:0] p8;
    logic [6:0] p7;
    logic       dv8, pe8, se8;
    logic       dv7, pe7, se7;

    int         checks = 0;
    int         errors = 0;

    int         dv8_n = 0, pe8_n = 0, se8_n = 0;
    int         dv7_n = 0, pe7_n = 0, se7_n = 0;
    logic [7:0] log8 [0:63];
    logic [6:0] log7 [0:63];

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (rx8),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p8),
        .data_valid (dv8),
        .par_err    (pe8),
        .stp_err    (se8)
    );

    uart_rx_param #(.DATA_WIDTH(7), .PRESCALE(16)) u_dut7 (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (rx7),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p7),
        .data_valid (dv7),
        .par_err    (pe7),
        .stp_err    (se7)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts every high cycle, so a strobe wider than one
    // clock shows up as an extra count.
    always @(negedge clk) begin
        if (dv8 === 1'b1) begin
            log8[dv8_n] <= p8;
            dv8_n       <= dv8_n + 1;
        end
        if (pe8 === 1'b1) pe8_n <= pe8_n + 1;
        if (se8 === 1'b1) se8_n <= se8_n + 1;
        if (dv7 === 1'b1) begin
            log7[dv7_n] <= p7;
            dv7_n       <= dv7_n + 1;
        end
        if (pe7 === 1'b1) pe7_n <= pe7_n + 1;
        if (se7 === 1'b1) se7_n <= se7_n + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel7, input logic v);
        if (sel7) rx7 = v;
        else      rx8 = v;
    endtask

    // glitch_bit >= 0 flips that data bit for one clock at its centre.
    // flip_typ toggles par_typ once the start bit has been sent.
    task automatic send_frame(input bit sel7, input logic [8:0] data, input int nbits,
                              input int presc, input bit with_par, input logic par_bit,
                              input logic stop_bit, input int glitch_bit, input bit flip_typ);
        set_line(sel7, 1'b0);
        tick(presc);
        if (flip_typ) par_typ = ~par_typ;
        for (int i = 0; i < nbits; i++) begin
            set_line(sel7, data[i]);
            if (i == glitch_bit) begin
                tick(presc / 2);
                set_line(sel7, ~data[i]);
                tick(1);
                set_line(sel7, data[i]);
                tick(presc / 2 - 1);
            end else begin
                tick(presc);
            end
        end
        if (with_par) begin
            set_line(sel7, par_bit);
            tick(presc);
        end
        set_line(sel7, stop_bit);
        tick(presc);
        set_line(sel7, 1'b1);
    endtask

    int b_dv, b_pe, b_se;
    logic [7:0] pre_rst;

    initial begin
        // ---------------- reset state ----------------
        tick(3);
        chk_eq("rst_p_data8", 32'(p8), 32'h0);
        chk_eq("rst_dv8", 32'(dv8), 32'h0);
        chk_eq("rst_pe8", 32'(pe8), 32'h0);
        chk_eq("rst_se8", 32'(se8), 32'h0);
        chk_eq("rst_p_data7", 32'(p7), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(10);

        // ---------------- 0xA5, even parity, correct bit; par_typ flipped mid-frame ----------------
        par_en = 1'b1; par_typ = 1'b0;
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        send_frame(1'b0, 9'h0A5, 8, 8, c_PAR_BUILD, 1'b0, 1'b1, -1, 1'b1);
        tick(24);
        chk_eq("good_dv_cnt", 32'(dv8_n - b_dv), 32'd1);
        chk_eq("good_pe_cnt", 32'(pe8_n - b_pe), 32'd0);
        chk_eq("good_se_cnt", 32'(se8_n - b_se), 32'd0);
        chk_eq("good_p_data", 32'(p8), 32'hA5);
        chk_eq("good_strobe_data", 32'(log8[b_dv]), 32'hA5);

        // ---------------- 0xA5, odd parity selected, parity bit 0 ----------------
        par_en = 1'b1; par_typ = 1'b1;
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        send_frame(1'b0, 9'h0A5, 8, 8, c_PAR_BUILD, 1'b0, 1'b1, -1, 1'b0);
        tick(24);
        chk_eq("par_dv_cnt", 32'(dv8_n - b_dv), c_PAR_BUILD ? 32'd0 : 32'd1);
        chk_eq("par_pe_cnt", 32'(pe8_n - b_pe), c_PAR_BUILD ? 32'd1 : 32'd0);
        chk_eq("par_se_cnt", 32'(se8_n - b_se), 32'd0);
        chk_eq("par_p_data", 32'(p8), 32'hA5);

        // ---------------- 0x3C, no parity, stop bit 0 ----------------
        par_en = 1'b0; par_typ = 1'b0;
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        send_frame(1'b0, 9'h03C, 8, 8, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        tick(32);
        chk_eq("stp_se_cnt", 32'(se8_n - b_se), 32'd1);
        chk_eq("stp_dv_cnt", 32'(dv8_n - b_dv), 32'd0);
        chk_eq("stp_pe_cnt", 32'(pe8_n - b_pe), 32'd0);
        chk_eq("stp_p_data", 32'(p8), 32'hA5);

        // ---------------- 3-clk glitch on idle line ----------------
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        rx8 = 1'b0;
        tick(3);
        rx8 = 1'b1;
        tick(32);
        chk_eq("glitch_dv_cnt", 32'(dv8_n - b_dv), 32'd0);
        chk_eq("glitch_pe_cnt", 32'(pe8_n - b_pe), 32'd0);
        chk_eq("glitch_se_cnt", 32'(se8_n - b_se), 32'd0);

        // ---------------- 0x0F with a one-clock flip inside bit 1 ----------------
        b_dv = dv8_n;
        send_frame(1'b0, 9'h00F, 8, 8, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        tick(24);
        chk_eq("vote_dv_cnt", 32'(dv8_n - b_dv), 32'd1);
        chk_eq("vote_p_data", 32'(p8), 32'h0F);

        // ---------------- back-to-back 0x55, 0xAA ----------------
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        send_frame(1'b0, 9'h055, 8, 8, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(1'b0, 9'h0AA, 8, 8, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        tick(24);
        chk_eq("b2b_dv_cnt", 32'(dv8_n - b_dv), 32'd2);
        chk_eq("b2b_first", 32'(log8[b_dv]), 32'h55);
        chk_eq("b2b_second", 32'(log8[b_dv + 1]), 32'hAA);
        chk_eq("b2b_err_cnt", 32'((pe8_n - b_pe) + (se8_n - b_se)), 32'd0);

        // ---------------- reset during bit 4 of 0x81 ----------------
        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        pre_rst = 8'h81;
        rx8 = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            rx8 = pre_rst[i];
            tick(8);
        end
        rx8 = pre_rst[4];
        tick(4);
        #2 rst = 1'b0;
        #1;
        chk_eq("midrst_p_data", 32'(p8), 32'h0);
        chk_eq("midrst_dv", 32'(dv8), 32'h0);
        chk_eq("midrst_flags", 32'({pe8, se8}), 32'h0);
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick(10);
        chk_eq("midrst_no_strobe", 32'((dv8_n - b_dv) + (pe8_n - b_pe) + (se8_n - b_se)), 32'd0);

        b_dv = dv8_n; b_pe = pe8_n; b_se = se8_n;
        send_frame(1'b0, 9'h081, 8, 8, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        tick(24);
        chk_eq("post_rst_dv_cnt", 32'(dv8_n - b_dv), 32'd1);
        chk_eq("post_rst_p_data", 32'(p8), 32'h81);
        chk_eq("post_rst_err_cnt", 32'((pe8_n - b_pe) + (se8_n - b_se)), 32'd0);

        // ---------------- DATA_WIDTH=7, PRESCALE=16 clean frame 0x4D ----------------
        par_en = 1'b1; par_typ = 1'b0;
        b_dv = dv7_n; b_pe = pe7_n; b_se = se7_n;
        send_frame(1'b1, 9'h04D, 7, 16, c_PAR_BUILD, 1'b0, 1'b1, -1, 1'b0);
        tick(48);
        chk_eq("w7_dv_cnt", 32'(dv7_n - b_dv), 32'd1);
        chk_eq("w7_p_data", 32'(p7), 32'h4D);
        chk_eq("w7_strobe_data", 32'(log7[b_dv]), 32'h4D);
        chk_eq("w7_err_cnt", 32'((pe7_n - b_pe) + (se7_n - b_se)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
